// File: rtl/inference_scheduler.sv
// inference_scheduler: loads one image into the input RAM, starts the network,
// waits for its result under a watchdog, picks the most probable class and
// hands digit + confidence to the consumer on a valid/ack handshake.
module inference_scheduler #(
  parameter int N_PIXELS  = 784,
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 65535
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Load_Valid,
  output logic                             Load_Ready,
  input  logic [DATA_W-1:0]                Load_Data,
  input  logic                             Load_Last,
  output logic                             Ram_We,
  output logic [ADDR_W-1:0]                Ram_Addr,
  output logic [DATA_W-1:0]                Ram_D,
  output logic                             Nn_Compute,
  input  logic                             Nn_R,
  input  logic [N_CLASSES-1:0][DATA_W-1:0] Probability,
  output logic                             Result_Valid,
  input  logic                             Result_Ack,
  output logic [3:0]                       Digit,
  output logic [DATA_W-1:0]                Confidence,
  output logic                             Busy,
  output logic [1:0]                       Err_Code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_ARGMAX = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pix_cnt_reg;
  logic [15:0]         wait_cnt_reg;
  logic [4:0]          arg_idx_reg;
  logic [DATA_W-1:0]   prob_reg [N_CLASSES];
  logic [DATA_W-1:0]   best_val_reg;
  logic [3:0]          best_idx_reg;
  logic                ram_we_reg;
  logic [ADDR_W-1:0]   ram_addr_reg;
  logic [DATA_W-1:0]   ram_d_reg;
  logic                nn_compute_reg;
  logic                result_valid_reg;
  logic [3:0]          digit_reg;
  logic [DATA_W-1:0]   confidence_reg;
  logic                busy_reg;
  logic [1:0]          err_reg;

  logic                accept;
  logic [ADDR_W-1:0]   beat_addr;
  logic                beat_final;
  logic                timeout_hit;
  logic                arg_active;
  logic [DATA_W-1:0]   cand_val;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; the final beat decides between compute and an error
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (Load_Last && beat_final)      state_next = S_START;
          else if (Load_Last || beat_final) state_next = S_IDLE;
          else                              state_next = S_LOAD;
        end
      end
      S_START:  state_next = S_WAIT;
      S_WAIT: begin
        if (Nn_R)             state_next = S_ARGMAX;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_ARGMAX: if (arg_idx_reg == 5'(N_CLASSES)) state_next = S_RESULT;
      S_RESULT: if (Result_Ack) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Combinational outputs and per-cycle decode; beat 0 is always taken from IDLE
  always_comb begin
    Load_Ready  = (state_reg == S_IDLE) || (state_reg == S_LOAD);
    accept      = Load_Valid && Load_Ready;
    beat_addr   = (state_reg == S_IDLE) ? '0 : pix_cnt_reg;
    beat_final  = (beat_addr == ADDR_W'(N_PIXELS - 1));
    // count+1 reaching TIMEOUT means this edge is the one where the count hits it
    timeout_hit = ({1'b0, wait_cnt_reg} + 17'd1) >= 17'(TIMEOUT);
    arg_active  = (state_reg == S_ARGMAX) && (arg_idx_reg < 5'(N_CLASSES));
    cand_val    = '0;
    if (arg_active) cand_val = prob_reg[arg_idx_reg[3:0]];
  end

  // Datapath: RAM write port, counters, argmax and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_cnt_reg      <= '0;
      wait_cnt_reg     <= '0;
      arg_idx_reg      <= '0;
      best_val_reg     <= '0;
      best_idx_reg     <= '0;
      ram_we_reg       <= 1'b0;
      ram_addr_reg     <= '0;
      ram_d_reg        <= '0;
      nn_compute_reg   <= 1'b0;
      result_valid_reg <= 1'b0;
      digit_reg        <= '0;
      confidence_reg   <= '0;
      busy_reg         <= 1'b0;
      err_reg          <= 2'b00;
      for (int i = 0; i < N_CLASSES; i++) prob_reg[i] <= '0;
    end else begin
      ram_we_reg <= accept;
      if (accept) begin
        ram_addr_reg <= beat_addr;
        ram_d_reg    <= Load_Data;
        pix_cnt_reg  <= beat_addr + ADDR_W'(1);
        // a new image clears any old error unless this beat is itself bad
        if (Load_Last && !beat_final)      err_reg <= 2'b01;
        else if (!Load_Last && beat_final) err_reg <= 2'b10;
        else                               err_reg <= 2'b00;
      end

      nn_compute_reg <= (state_reg == S_START);

      if (state_reg == S_WAIT) begin
        if ({1'b0, wait_cnt_reg} < 17'(TIMEOUT)) wait_cnt_reg <= wait_cnt_reg + 16'd1;
        if (Nn_R) begin
          for (int i = 0; i < N_CLASSES; i++) prob_reg[i] <= Probability[i];
        end else if (timeout_hit) begin
          err_reg <= 2'b11;
        end
      end else begin
        wait_cnt_reg <= '0;
      end

      if (state_reg == S_ARGMAX) arg_idx_reg <= arg_idx_reg + 5'd1;
      else                       arg_idx_reg <= '0;

      // strict greater-than keeps the lowest index on ties
      if (arg_active && ((arg_idx_reg == 5'd0) || (cand_val > best_val_reg))) begin
        best_val_reg <= cand_val;
        best_idx_reg <= arg_idx_reg[3:0];
      end

      if ((state_reg == S_ARGMAX) && (arg_idx_reg == 5'(N_CLASSES))) begin
        digit_reg      <= best_idx_reg;
        confidence_reg <= best_val_reg;
      end

      result_valid_reg <= (state_next == S_RESULT);
      busy_reg         <= (state_next != S_IDLE);
    end
  end

  assign Ram_We       = ram_we_reg;
  assign Ram_Addr     = ram_addr_reg;
  assign Ram_D        = ram_d_reg;
  assign Nn_Compute   = nn_compute_reg;
  assign Result_Valid = result_valid_reg;
  assign Digit        = digit_reg;
  assign Confidence   = confidence_reg;
  assign Busy         = busy_reg;
  assign Err_Code     = err_reg;

endmodule

// File: tb/tb_inference_scheduler.sv
// tb_inference_scheduler: randomized scenarios for inference_scheduler checked
// against a plain reference model of loading, timing and argmax selection.
`timescale 1ns/1ps
module tb_inference_scheduler;
  localparam int NP = 784;
  localparam int NC = 10;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int TO = 100;
  typedef logic [NC-1:0][DW-1:0] prob_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Load_Valid = 1'b0;
  logic          Load_Ready;
  logic [DW-1:0] Load_Data = '0;
  logic          Load_Last = 1'b0;
  logic          Ram_We;
  logic [AW-1:0] Ram_Addr;
  logic [DW-1:0] Ram_D;
  logic          Nn_Compute;
  logic          Nn_R = 1'b0;
  prob_t         Probability = '0;
  logic          Result_Valid;
  logic          Result_Ack = 1'b0;
  logic [3:0]    Digit;
  logic [DW-1:0] Confidence;
  logic          Busy;
  logic [1:0]    Err_Code;

  inference_scheduler #(
    .N_PIXELS(NP), .N_CLASSES(NC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Load_Valid(Load_Valid), .Load_Ready(Load_Ready), .Load_Data(Load_Data), .Load_Last(Load_Last),
    .Ram_We(Ram_We), .Ram_Addr(Ram_Addr), .Ram_D(Ram_D),
    .Nn_Compute(Nn_Compute), .Nn_R(Nn_R), .Probability(Probability),
    .Result_Valid(Result_Valid), .Result_Ack(Result_Ack),
    .Digit(Digit), .Confidence(Confidence), .Busy(Busy), .Err_Code(Err_Code)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // observed RAM writes and compute pulses, sampled mid-cycle
  logic [AW+DW-1:0] wr_q[$];
  int compute_cnt = 0;
  int compute_cyc = -1;
  always @(negedge Clk) begin
    if (Ram_We === 1'b1) wr_q.push_back({Ram_Addr, Ram_D});
    if (Nn_Compute === 1'b1) begin
      compute_cnt++;
      compute_cyc = cyc;
    end
  end

  logic [DW-1:0] exp_pix [NP];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_beats(input int start, input int n, input int last_at);
    for (int k = start; k < start + n; k++) begin
      Load_Valid = 1'b1;
      Load_Data  = DW'($urandom);
      exp_pix[k] = Load_Data;
      Load_Last  = (k == last_at);
      tick();
    end
    Load_Valid = 1'b0;
    Load_Last  = 1'b0;
  endtask

  function automatic prob_t rand_prob(input bit tie_heavy);
    prob_t v;
    for (int i = 0; i < NC; i++)
      v[i] = tie_heavy ? DW'($urandom_range(0, 5) * 13000) : DW'($urandom);
    return v;
  endfunction

  task automatic pulse_nnr(input prob_t v, output int e);
    Probability = v;
    Nn_R = 1'b1;
    tick();
    e = cyc;
    Nn_R = 1'b0;
    Probability = rand_prob(1'b0);
  endtask

  task automatic wait_valid(input int budget, output int seen);
    bit found;
    found = 1'b0;
    seen = -1;
    for (int i = 0; i < budget && !found; i++) begin
      if (Result_Valid === 1'b1) begin
        seen = cyc;
        found = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  // Reference argmax: largest value, earliest index on ties
  function automatic void ref_argmax(input prob_t v, output int idx, output logic [DW-1:0] val);
    idx = 0;
    val = v[0];
    for (int i = 1; i < NC; i++)
      if (v[i] > val) begin
        idx = i;
        val = v[i];
      end
  endfunction

  function automatic logic [52:0] outs();
    return {Load_Ready, Ram_We, Ram_Addr, Ram_D, Nn_Compute, Result_Valid,
            Digit, Confidence, Busy, Err_Code};
  endfunction

  function automatic logic [52:0] reset_outs();
    return {1'b1, 52'd0};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (outs() !== reset_outs()) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required %h", outs(), reset_outs());
    end
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (outs() !== reset_outs()) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h required %h", outs(), reset_outs());
    end
  endtask

  task automatic test_full_image();
    int t_acc;
    int nbad;
    wr_q.delete();
    compute_cnt = 0;
    drive_beats(0, NP, NP - 1);
    t_acc = cyc;
    checks++;
    if ({Ram_We, Ram_Addr, Nn_Compute, Busy} !== {1'b1, AW'(NP - 1), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL last_write: we/addr/compute/busy=%b/%0d/%b/%b required 1/%0d/0/1",
               Ram_We, Ram_Addr, Nn_Compute, Busy, NP - 1);
    end
    tick();
    checks++;
    if ({Nn_Compute, Load_Ready} !== 2'b10) begin
      errors++;
      $display("FAIL compute_cycle: compute/ready=%b/%b required 1/0", Nn_Compute, Load_Ready);
    end
    // producer offers a beat while not ready: it must not be taken
    for (int i = 0; i < 5; i++) begin
      Load_Valid = 1'b1;
      Load_Data = DW'($urandom);
      tick();
    end
    Load_Valid = 1'b0;
    checks++;
    if (wr_q.size() != NP) begin
      errors++;
      $display("FAIL write_count: got %0d writes required %0d", wr_q.size(), NP);
    end
    nbad = 0;
    for (int k = 0; k < NP && k < wr_q.size(); k++) begin
      checks++;
      if (wr_q[k] !== {AW'(k), exp_pix[k]}) begin
        errors++;
        nbad++;
        if (nbad <= 5)
          $display("FAIL write_beat %0d: addr/data=%0d/%h required %0d/%h",
                   k, wr_q[k][AW+DW-1:DW], wr_q[k][DW-1:0], k, exp_pix[k]);
      end
    end
    checks++;
    if (compute_cnt != 1 || compute_cyc != t_acc + 1) begin
      errors++;
      $display("FAIL compute_pulse: count=%0d at cycle %0d required 1 at %0d",
               compute_cnt, compute_cyc, t_acc + 1);
    end
    checks++;
    if ({Err_Code, Busy} !== 3'b001) begin
      errors++;
      $display("FAIL wait_status: err/busy=%b/%b required 00/1", Err_Code, Busy);
    end
    $display("full_image: %0d writes, compute at cycle %0d", wr_q.size(), compute_cyc);
  endtask

  // continues from WAIT after test_full_image
  task automatic test_argmax_fixed();
    prob_t v;
    int e, seen;
    for (int i = 0; i < NC; i++) v[i] = 16'h0010;
    v[0] = 16'h0100;
    v[1] = 16'h0800;
    v[2] = 16'h0200;
    v[3] = 16'h0800;
    pulse_nnr(v, e);
    wait_valid(30, seen);
    checks++;
    if (seen != e + 11) begin
      errors++;
      $display("FAIL argmax_latency: valid at cycle %0d required %0d", seen, e + 11);
    end
    checks++;
    if ({Digit, Confidence} !== {4'd1, 16'h0800}) begin
      errors++;
      $display("FAIL argmax_tie: digit/conf=%0d/%h required 1/0800", Digit, Confidence);
    end
    Result_Ack = 1'b1;
    tick();
    Result_Ack = 1'b0;
    checks++;
    if ({Result_Valid, Load_Ready, Busy} !== 3'b010) begin
      errors++;
      $display("FAIL ack_release: valid/ready/busy=%b/%b/%b required 0/1/0",
               Result_Valid, Load_Ready, Busy);
    end
    $display("argmax_fixed: digit=%0d conf=%h latency=%0d", Digit, Confidence, seen - e);
  endtask

  task automatic test_random_images();
    prob_t v;
    int e, seen, ridx;
    logic [DW-1:0] rval;
    for (int it = 0; it < 3; it++) begin
      drive_beats(0, NP, NP - 1);
      repeat (2 + $urandom_range(0, 20)) tick();
      v = rand_prob(it != 2);
      ref_argmax(v, ridx, rval);
      pulse_nnr(v, e);
      wait_valid(30, seen);
      checks++;
      if (seen != e + 11 || Digit !== 4'(ridx) || Confidence !== rval || Err_Code !== 2'b00) begin
        errors++;
        $display("FAIL random_image %0d: cyc/digit/conf/err=%0d/%0d/%h/%b required %0d/%0d/%h/00",
                 it, seen, Digit, Confidence, Err_Code, e + 11, ridx, rval);
      end
      repeat ($urandom_range(0, 3)) tick();
      Result_Ack = 1'b1;
      tick();
      Result_Ack = 1'b0;
      $display("random_image %0d: digit=%0d conf=%h expected %0d/%h", it, Digit, Confidence, ridx, rval);
    end
  endtask

  task automatic test_length_errors();
    wr_q.delete();
    compute_cnt = 0;
    // single beat with Last straight from IDLE is a short image
    drive_beats(0, 1, 0);
    checks++;
    if ({Err_Code, Busy, Load_Ready} !== 4'b0101) begin
      errors++;
      $display("FAIL short_single: err/busy/ready=%b/%b/%b required 01/0/1", Err_Code, Busy, Load_Ready);
    end
    // next image start clears the error
    drive_beats(0, 1, 500);
    checks++;
    if ({Err_Code, Busy} !== 3'b001) begin
      errors++;
      $display("FAIL err_clear: err/busy=%b/%b required 00/1", Err_Code, Busy);
    end
    drive_beats(1, 500, 500);
    repeat (3) tick();
    checks++;
    if ({Err_Code, Busy, Load_Ready} !== 4'b0101 || compute_cnt != 0 || wr_q.size() != 502) begin
      errors++;
      $display("FAIL short_image: err/busy/ready=%b/%b/%b computes=%0d writes=%0d required 01/0/1 0 502",
               Err_Code, Busy, Load_Ready, compute_cnt, wr_q.size());
    end
    $display("short_image: err=%b writes=%0d", Err_Code, wr_q.size());
    drive_beats(0, NP, -1);
    repeat (3) tick();
    checks++;
    if ({Err_Code, Busy, Load_Ready} !== 4'b1001 || compute_cnt != 0) begin
      errors++;
      $display("FAIL long_image: err/busy/ready=%b/%b/%b computes=%0d required 10/0/1 0",
               Err_Code, Busy, Load_Ready, compute_cnt);
    end
    $display("long_image: err=%b computes=%0d", Err_Code, compute_cnt);
  endtask

  task automatic test_timeout();
    int t_acc;
    int e;
    drive_beats(0, NP, NP - 1);
    t_acc = cyc;
    // WAIT is entered at edge t_acc+1; the error lands TO edges later
    for (int i = 0; i < 200 && cyc < t_acc + TO; i++) tick();
    checks++;
    if ({Err_Code, Busy} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_early: err/busy=%b/%b at cycle %0d required 00/1", Err_Code, Busy, cyc);
    end
    tick();
    checks++;
    if ({Err_Code, Busy, Load_Ready} !== 4'b1101) begin
      errors++;
      $display("FAIL timeout: err/busy/ready=%b/%b/%b at cycle %0d required 11/0/1",
               Err_Code, Busy, Load_Ready, cyc);
    end
    // late Nn_R and stray ack while idle do nothing
    Result_Ack = 1'b1;
    pulse_nnr(rand_prob(1'b0), e);
    repeat (14) tick();
    Result_Ack = 1'b0;
    checks++;
    if ({Err_Code, Busy, Result_Valid} !== 4'b1100) begin
      errors++;
      $display("FAIL idle_ignore: err/busy/valid=%b/%b/%b required 11/0/0", Err_Code, Busy, Result_Valid);
    end
    $display("timeout: err=%b at cycle %0d", Err_Code, t_acc + TO + 1);
  endtask

  task automatic test_result_hold();
    prob_t v;
    int e, seen, ridx;
    logic [DW-1:0] rval;
    drive_beats(0, NP, NP - 1);
    repeat (3) tick();
    v = rand_prob(1'b1);
    ref_argmax(v, ridx, rval);
    pulse_nnr(v, e);
    wait_valid(30, seen);
    checks++;
    if (seen != e + 11) begin
      errors++;
      $display("FAIL hold_latency: valid at %0d required %0d", seen, e + 11);
    end
    for (int i = 0; i < 20; i++) begin
      Nn_R = (i == 5);
      Probability = rand_prob(1'b0);
      checks++;
      if ({Result_Valid, Digit, Confidence} !== {1'b1, 4'(ridx), rval}) begin
        errors++;
        $display("FAIL hold_stable %0d: valid/digit/conf=%b/%0d/%h required 1/%0d/%h",
                 i, Result_Valid, Digit, Confidence, ridx, rval);
      end
      tick();
    end
    Nn_R = 1'b0;
    Result_Ack = 1'b1;
    tick();
    Result_Ack = 1'b0;
    checks++;
    if ({Result_Valid, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL hold_ack: valid/busy=%b/%b required 0/0", Result_Valid, Busy);
    end
    $display("result_hold: digit=%0d conf=%h held 20 cycles", ridx, rval);
  endtask

  task automatic test_clean_image(input string tag);
    prob_t v;
    int e, seen, ridx;
    logic [DW-1:0] rval;
    compute_cnt = 0;
    drive_beats(0, NP, NP - 1);
    repeat (2) tick();
    v = rand_prob(1'b1);
    ref_argmax(v, ridx, rval);
    pulse_nnr(v, e);
    wait_valid(30, seen);
    checks++;
    if (seen != e + 11 || compute_cnt != 1 || Digit !== 4'(ridx) || Confidence !== rval) begin
      errors++;
      $display("FAIL %s: cyc/computes/digit/conf=%0d/%0d/%0d/%h required %0d/1/%0d/%h",
               tag, seen, compute_cnt, Digit, Confidence, e + 11, ridx, rval);
    end
    Result_Ack = 1'b1;
    tick();
    Result_Ack = 1'b0;
    $display("%s: digit=%0d conf=%h", tag, Digit, Confidence);
  endtask

  task automatic test_reset_mid_load();
    compute_cnt = 0;
    drive_beats(0, 300, -1);
    Load_Valid = 1'b1;
    Load_Data = DW'($urandom);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (outs() !== reset_outs()) begin
      errors++;
      $display("FAIL reset_mid_load: outputs=%h required %h", outs(), reset_outs());
    end
    tick();
    Load_Valid = 1'b0;
    Reset = 1'b0;
    wr_q.delete();
    repeat (4) tick();
    checks++;
    if (wr_q.size() != 0 || compute_cnt != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_load: writes/computes/busy=%0d/%0d/%b required 0/0/0",
               wr_q.size(), compute_cnt, Busy);
    end
    $display("reset_mid_load: aborted at beat 300");
    test_clean_image("after_load_reset");
  endtask

  task automatic test_reset_mid_argmax();
    int e, seen;
    drive_beats(0, NP, NP - 1);
    repeat (2) tick();
    pulse_nnr(rand_prob(1'b0), e);
    repeat (4) tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (outs() !== reset_outs()) begin
      errors++;
      $display("FAIL reset_mid_argmax: outputs=%h required %h", outs(), reset_outs());
    end
    tick();
    Reset = 1'b0;
    wait_valid(15, seen);
    checks++;
    if (seen != -1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_argmax: valid seen at %0d busy=%b required never/0", seen, Busy);
    end
    $display("reset_mid_argmax: aborted 4 cycles into argmax");
    test_clean_image("after_argmax_reset");
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_argmax_fixed();
    test_random_images();
    test_length_errors();
    test_timeout();
    test_result_hold();
    test_reset_mid_load();
    test_reset_mid_argmax();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
